// File: rtl/hex_8digit_scanner.sv
// hex_8digit_scanner: multiplexes a once-per-frame snapshot of a 32-bit value onto an 8-digit common-anode display.
// Defining HEX_SCANNER_LEADING_ZERO_BLANK_EN blanks leading-zero digits, except digit 0 and digits whose decimal point is lit.
module hex_8digit_scanner #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_mask_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_done_o
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] BLANK_T = TW'(BLANK_CYCLES);
  // Active-low {g..a} patterns for hex digits 0..F, with digit 0 in the low bits
  localparam logic [111:0] ENC = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   snap_q;
  logic          load_pending_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q;
  logic          wrap, frame_end, lit;
  logic [3:0]    nib;
  always_comb begin
    wrap      = tick_q == LAST;
    frame_end = wrap && digit_q == 3'd7;
    tick_d    = wrap ? '0 : tick_q + 1'b1;
    digit_d   = digit_q + 3'(wrap);
    nib       = snap_q[{digit_q, 2'b00} +: 4];
`ifdef HEX_SCANNER_LEADING_ZERO_BLANK_EN
    lit = tick_q >= BLANK_T &&
          !(digit_q != 3'd0 && (snap_q >> {digit_q, 2'b00}) == 32'd0 && !dp_mask_i[digit_q]);
`else
    lit = tick_q >= BLANK_T;
`endif
    an_d  = lit ? ~(8'b1 << digit_q) : 8'hFF;
    seg_d = lit ? ENC[7'(nib) * 7'd7 +: 7] : 7'h7F;
    dp_d  = lit ? ~dp_mask_i[digit_q] : 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      tick_q         <= '0;
      digit_q        <= '0;
      snap_q         <= '0;
      load_pending_q <= 1'b1;
      an_q           <= 8'hFF;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      tick_q         <= tick_d;
      digit_q        <= digit_d;
      if (load_pending_q || frame_end) snap_q <= data_i;
      load_pending_q <= 1'b0;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_done_q   <= frame_end;
    end
  end
  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_hex_8digit_scanner.sv
// tb_hex_8digit_scanner: randomized scoreboard bench comparing the scanner against a frame/slot arithmetic model.
module tb_hex_8digit_scanner;
  localparam int TD = 10;
  localparam int BC = 2;
  localparam int FRAME = 8 * TD;
  logic        clk = 1'b0;
  logic        clear_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_mask_i = '0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_done_o;
  logic [6:0]  enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [16:0] exp_q [$];
  logic [16:0] got_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          c = 0;
  logic [31:0] fsnap = '0;
  logic [31:0] dcur = '0;
  logic [7:0]  mcur = '0;

  always #5 clk = ~clk;

  hex_8digit_scanner #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk_i(clk), .clear_i(clear_i), .data_i(data_i), .dp_mask_i(dp_mask_i),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o), .frame_done_o(frame_done_o)
  );

  // c is the number of non-reset edges already seen; the display state for edge c is derived arithmetically.
  task automatic step(input logic clr, input logic [31:0] d, input logic [7:0] m);
    int dg, tk;
    logic lit;
    logic [3:0] nib;
    logic [7:0] an_e;
    logic fd;
    @(negedge clk);
    clear_i = clr; data_i = d; dp_mask_i = m;
    if (clr) begin
      exp_q.push_back({8'hFF, 7'h7F, 1'b1, 1'b0});
      c = 0;
      fsnap = '0;
    end else begin
      dg  = (c / TD) % 8;
      tk  = c % TD;
      lit = tk >= BC;
`ifdef HEX_SCANNER_LEADING_ZERO_BLANK_EN
      if (dg > 0 && (fsnap >> (4 * dg)) == 0 && !m[dg]) lit = 1'b0;
`endif
      nib  = fsnap[4*dg +: 4];
      an_e = 8'hFF;
      an_e[dg] = 1'b0;
      fd = (c % FRAME) == FRAME - 1;
      exp_q.push_back(lit ? {an_e, enc[nib], ~m[dg], fd} : {8'hFF, 7'h7F, 1'b1, fd});
      if (c == 0 || fd) fsnap = d;
      c++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, dcur, mcur);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      n_chk++;
      if ({an_o, seg_o, dp_o, frame_done_o} !== got_e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                 $time, an_o, seg_o, dp_o, frame_done_o, got_e[16:9], got_e[8:2], got_e[1], got_e[0]);
      end
      n_chk++;
      if ($countones(~an_o) > 1) begin
        n_fail++;
        $display("FAIL one_anode t=%0t got an=%h want at most one low bit", $time, an_o);
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 8'h00);
    dcur = 32'h0123_89AF; mcur = 8'h00;
    run(2 * FRAME + 30);
    dcur = 32'hFFFF_FFFF;
    run(2 * FRAME);
    mcur = 8'h10;
    run(FRAME + 5);
    mcur = 8'h00;
    while (c % FRAME != 35) run(1);
    dcur = 32'h7654_3210;
    for (int i = 0; i < 3; i++) step(1'b1, dcur, mcur);
    run(FRAME + 10);
    dcur = 32'h0000_00A5;
    run(2 * FRAME + 5);
    dcur = 32'h0003_0000; mcur = 8'h40;
    run(2 * FRAME);
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 19) == 0) dcur = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) mcur = 8'($urandom);
      step($urandom_range(0, 199) == 0, dcur, mcur);
    end
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_8digit_scanner.md
# hex_8digit_scanner

Time-multiplexed driver for the board's 8-digit common-anode 7-segment display, sitting directly downstream of the 32-bit up/down counter. It snapshots the 32-bit count once per refresh frame, scans the eight digits in turn with anode dead-time between slots, and drives active-low anode, segment and decimal-point pins. It runs on the 100 MHz system clock, not the 1 Hz count clock.

## Interface
- TICK_DIV, 100000: Clock cycles per digit slot (1 ms at 100 MHz). Minimum 4.
- BLANK_CYCLES, 4: Cycles at the start of each slot with all anodes off. Range 1 to TICK_DIV-2.
- Clock  in  1  System clock, 100 MHz. All logic is on the rising edge.
- Clear  in  1  Synchronous reset, active-high.
- Data  in  32  Value to display. Digit d shows Data[4d+3:4d].
- DP_mask  in  8  Bit d=1 lights the decimal point of digit d. Sampled live, not snapshotted.
- AN  out  8  Anodes, active-low. AN[7] is the leftmost digit.
- Seg  out  7  Segments {CG,CF,CE,CD,CC,CB,CA}, active-low.
- DP  out  1  Decimal point, active-low.
- Frame_done  out  1  One-cycle pulse after digit 7's slot ends.

## Operation
- **Reset state.** While Clear is high:
  - tick=0, digit=0, snap=0, load_pending=1.
  - AN=8'hFF, Seg=7'h7F, DP=1, Frame_done=0.
- **Tick counter.** tick counts 0..TICK_DIV-1 and then wraps to 0.
  - At the wrap, digit increments modulo 8 (7→0).
- **Snapshot.** snap<=Data on the first cycle after Clear deasserts (load_pending=1, which then clears).
  - It also loads on every cycle where tick==TICK_DIV-1 and digit==7.
  - Data changes inside a frame never tear the displayed value.
- **Slot output.** Outputs are computed from the current tick, digit and snap, then registered.
  - **Blank window** (tick < BLANK_CYCLES): AN=8'hFF, Seg=7'h7F, DP=1.
  - **Otherwise:** AN = ~(8'b1<<digit), Seg = enc(snap[4·digit+3:4·digit]), DP = ~DP_mask[digit].
- **Hex encoding** (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex)
- **Frame_done.** Registered high for exactly one cycle following the digit 7→0 wrap cycle, i.e. the same edge that loads snap.
- **Invariant.** At most one AN bit is low in any cycle.

## Timing
- **Latency.** One cycle from a tick/digit state to AN/Seg/DP.
  - Example: the first lit cycle of a slot is registered at tick==BLANK_CYCLES and is visible at tick==BLANK_CYCLES+1.
- **Frame period.** 8·TICK_DIV cycles (8 ms default, 125 Hz refresh).
- **Snapshot to visible.** Digit 0 of a new snapshot lights BLANK_CYCLES+1 cycles after the load edge.
- **First frame after reset.**
  - Clear deasserts at edge N, so the first non-reset edge is N+1.
  - Snapshot loads at edge N+1.
  - Digit 0 lights at edge N+BLANK_CYCLES+1.
- **Clear mid-slot.** On the next edge, outputs go dark and the scan restarts at digit 0 with a fresh snapshot load after release. No partial slot completes.
- **Simultaneous snapshot load and Clear.** Clear wins; snap=0.
- **Clock gating.** No clock enable. Scanning never stops while Clear is low.

## Configuration
- **Macro:** HEX_SCANNER_LEADING_ZERO_BLANK_EN.
- **Defined:**
  - In the lit window, digit d (d≥1) is blanked (AN=8'hFF, Seg=7'h7F, DP=1) when snap[31:4d]==0, unless DP_mask[d]=1.
  - Digit 0 is always shown.
  - Example: snap=32'h0000_00A5 lights only digits 1 and 0.
- **Undefined:** all eight digits are always lit, including leading zeros.

## Test plan
All scenarios use TICK_DIV=10, BLANK_CYCLES=2 and a 10 ns clock.
- **Reset values.** Hold Clear 5 cycles → AN=FF, Seg=7F, DP=1, Frame_done=0 on every cycle.
- **Scan sequence.** Release Clear with Data=32'h0123_89AF.
  - Slot order: AN=FE, FD, FB, F7, EF, DF, BF, 7F.
  - Seg per slot: 0E, 08, 10, 00, 30, 24, 79, 40.
  - Each slot lights 8 cycles, preceded by 2 all-off cycles.
  - Frame_done pulses every 80 cycles.
- **No tearing.** Change Data to 32'hFFFF_FFFF mid-frame.
  - Current frame keeps the old digits.
  - Next frame shows Seg=0E on all digits, starting the cycle after Frame_done.
- **Decimal point.** DP_mask=8'h10 → DP=0 only while AN=EF, else 1.
- **Reset mid-slot.** Assert Clear at tick=5 of digit 3 → outputs dark on the next edge. After release, the scan restarts at AN=FE with new Data.
- **Leading-zero blank.** With the macro defined, Data=32'h0000_00A5 → only AN=FE (Seg=12) and FD (Seg=08) ever go low. Undefined → six additional slots show Seg=40.
